elevator_ctrl_n: RTL and testbench

Parametrised N-floor elevator car controller; next generation of the team's fixed 4-floor `elevator` block. It latches hall (up/down) and car-panel requests, drives request LEDs, and moves the car one floor per `MOVE_CYC` cycles with directional (collective) scheduling. It opens the door for `DOOR_CYC` cycles, with a door-hold input. It sits between button debouncers and the floor/direction display and door actuator.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elev_timer.sv | 41 ++++
 rtl/elevator_ctrl_n.sv | 194 +++++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state, direction encodings and timer sizing for the elevator controller
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        DOOR = 2'b10
    } state_e;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    // Width needed to hold the larger of the two reload values (cycles-1).
    function automatic int timer_w(input int move_cyc, input int door_cyc);
        int m;
        m = (move_cyc > door_cyc) ? move_cyc : door_cyc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/elev_timer.sv
// elev_timer: loadable down-counter that pulses expire when a loaded count runs out
module elev_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    // Load wins; otherwise count down and stop once zero has been presented.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = value_i;
            run_d = 1'b1;
        end else if (run_q) begin
            run_d = (cnt_q != '0);
            cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor collective-scheduling elevator car controller
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS   = 4,
    parameter int FLOOR_W  = $clog2(FLOORS),
    parameter int MOVE_CYC = 8,
    parameter int DOOR_CYC = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [FLOORS-1:0]  hall_up_i,
    input  logic [FLOORS-1:0]  hall_dn_i,
    input  logic [FLOORS-1:0]  car_req_i,
    input  logic               hold_open_i,
    output logic [FLOORS-1:0]  hall_up_led_o,
    output logic [FLOORS-1:0]  hall_dn_led_o,
    output logic [FLOORS-1:0]  car_led_o,
    output logic               door_open_o,
    output logic [1:0]         direction_o,
    output logic [FLOOR_W-1:0] floor_o
);

    localparam int TW = timer_w(MOVE_CYC, DOOR_CYC);
    localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_CYC - 1);
    localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYC - 1);
    localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i == int'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] above(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] below(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [1:0]         dir_q, dir_d;
    logic [FLOOR_W-1:0] floor_q, floor_d, nf;
    logic [FLOORS-1:0]  up_q, up_d, dn_q, dn_d, car_q, car_d;
    logic [FLOORS-1:0]  up_r, dn_r, car_r, any_r, fsel, nsel;
    logic [FLOORS-1:0]  car_abs, up_abs, dn_abs, clr_up, clr_dn, clr_car;
    logic               in_door, going_up, restart, at_f, above_f, below_f;
    logic               ahead_f, behind_f, ahead_n, stop_n;
    logic               tmr_load, tmr_expire;
    logic [TW-1:0]      tmr_val;

    elev_timer #(.W(TW)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (tmr_load),
        .value_i  (tmr_val),
        .expire_o (tmr_expire)
    );

    // Effective requests: latched bits plus this cycle's presses, minus presses the open door absorbs.
    always_comb begin
        in_door  = (state_q == DOOR);
        going_up = (dir_q == DIR_UP);
        fsel     = onehot(floor_q);
        car_abs  = in_door ? fsel : '0;
        up_abs   = (in_door && dir_q == DIR_UP) ? fsel : '0;
        dn_abs   = (in_door && dir_q == DIR_DN) ? fsel : '0;
        up_r     = up_q | (hall_up_i & UP_MASK & ~up_abs);
        dn_r     = dn_q | (hall_dn_i & DN_MASK & ~dn_abs);
        car_r    = car_q | (car_req_i & ~car_abs);
        restart  = in_door && (hold_open_i || |(car_req_i & car_abs)
                   || |(hall_up_i & up_abs) || |(hall_dn_i & dn_abs));
        any_r    = up_r | dn_r | car_r;
        at_f     = |(any_r & fsel);
        above_f  = |(any_r & above(floor_q));
        below_f  = |(any_r & below(floor_q));
        ahead_f  = going_up ? above_f : below_f;
        behind_f = going_up ? below_f : above_f;
        nf       = going_up ? floor_q + 1'b1 : floor_q - 1'b1;
        nsel     = onehot(nf);
        ahead_n  = |(any_r & (going_up ? above(nf) : below(nf)));
        stop_n   = |(car_r & nsel) | |((going_up ? up_r : dn_r) & nsel)
                   | (!ahead_n && |((going_up ? dn_r : up_r) & nsel));
    end

    // Scheduling FSM: next state, direction, floor step, timer control and request clears.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        floor_d  = floor_q;
        tmr_load = 1'b0;
        tmr_val  = MOVE_LD;
        clr_up   = '0;
        clr_dn   = '0;
        clr_car  = '0;
        case (state_q)
            IDLE: begin
                dir_d = DIR_IDLE;
                if (at_f) begin
                    state_d  = DOOR;
                    dir_d    = DIR_UP;
                    clr_up   = fsel;
                    clr_dn   = fsel;
                    clr_car  = fsel;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (above_f || below_f) begin
                    state_d  = MOVE;
                    dir_d    = above_f ? DIR_UP : DIR_DN;
                    tmr_load = 1'b1;
                end
            end
            MOVE: begin
                if (tmr_expire) begin
                    floor_d  = nf;
                    tmr_load = 1'b1;
                    if (stop_n) begin
                        state_d = DOOR;
                        tmr_val = DOOR_LD;
                        clr_car = nsel;
                        clr_up  = (going_up || !ahead_n) ? nsel : '0;
                        clr_dn  = (!going_up || !ahead_n) ? nsel : '0;
                    end
                end
            end
            DOOR: begin
                if (restart) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (tmr_expire) begin
                    if (ahead_f) begin
                        state_d  = MOVE;
                        tmr_load = 1'b1;
                    end else if (at_f) begin
                        dir_d    = going_up ? DIR_DN : DIR_UP;
                        clr_up   = fsel;
                        clr_dn   = fsel;
                        clr_car  = fsel;
                        tmr_load = 1'b1;
                        tmr_val  = DOOR_LD;
                    end else if (behind_f) begin
                        state_d  = MOVE;
                        dir_d    = going_up ? DIR_DN : DIR_UP;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                dir_d   = DIR_IDLE;
            end
        endcase
        up_d  = up_r & ~clr_up;
        dn_d  = dn_r & ~clr_dn;
        car_d = car_r & ~clr_car;
    end

    // Controller state; reset drops every pending request and parks the car at ground.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dir_q   <= DIR_IDLE;
            floor_q <= '0;
            up_q    <= '0;
            dn_q    <= '0;
            car_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            car_q   <= car_d;
        end
    end

    assign hall_up_led_o = up_q;
    assign hall_dn_led_o = dn_q;
    assign car_led_o     = car_q;
    assign door_open_o   = (state_q == DOOR);
    assign direction_o   = dir_q;
    assign floor_o       = floor_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: scoreboard bench; stimulus queues expected output snapshots, monitor compares on every change
module tb_elevator_ctrl_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] hu = '0, hd = '0, cr = '0;
    logic [3:0] hu_led, hd_led, car_led;
    logic       door;
    logic [1:0] dir, flr;
    logic       probe = 1'b0;
    int         checks = 0, failures = 0, cyc = 0;

    typedef struct packed {
        logic [1:0] flr;
        logic [1:0] dir;
        logic       door;
        logic [3:0] up;
        logic [3:0] dn;
        logic [3:0] car;
    } snap_t;

    typedef struct {
        snap_t s;
        int    at;
        string name;
    } exp_t;

    exp_t  q[$];
    snap_t cur, prev;
    logic  primed = 1'b0;

    elevator_ctrl_n #(.FLOORS(4), .MOVE_CYC(4), .DOOR_CYC(6)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .hall_up_i     (hu),
        .hall_dn_i     (hd),
        .car_req_i     (cr),
        .hold_open_i   (hold),
        .hall_up_led_o (hu_led),
        .hall_dn_led_o (hd_led),
        .car_led_o     (car_led),
        .door_open_o   (door),
        .direction_o   (dir),
        .floor_o       (flr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges so far.
    always @(posedge clk) cyc++;

    task automatic expect_ev(input string name, input int at, input logic [1:0] f, input logic [1:0] d,
                             input logic o, input logic [3:0] u, input logic [3:0] n, input logic [3:0] c);
        exp_t e;
        e.s    = '{flr: f, dir: d, door: o, up: u, dn: n, car: c};
        e.at   = at;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic check_ev(input exp_t e, input snap_t s);
        checks++;
        if (s !== e.s || (e.at >= 0 && e.at != cyc)) begin
            failures++;
            $display("FAIL %s: got floor=%0d dir=%b door=%b up=%b dn=%b car=%b cyc=%0d, want floor=%0d dir=%b door=%b up=%b dn=%b car=%b cyc=%0d",
                     e.name, s.flr, s.dir, s.door, s.up, s.dn, s.car, cyc,
                     e.s.flr, e.s.dir, e.s.door, e.s.up, e.s.dn, e.s.car, e.at);
        end
    endtask

    // Monitor: compares on explicit probes, and on every output change outside reset.
    always begin
        exp_t e;
        @(negedge clk or posedge probe);
        cur = {flr, dir, door, hu_led, hd_led, car_led};
        if (probe || (primed && rst_n && cur !== prev)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected: output change at cyc=%0d floor=%0d dir=%b door=%b up=%b dn=%b car=%b with nothing expected",
                         cyc, cur.flr, cur.dir, cur.door, cur.up, cur.dn, cur.car);
            end else begin
                e = q.pop_front();
                check_ev(e, cur);
            end
        end
        prev   = cur;
        primed = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
        hu = u;
        hd = d;
        cr = c;
        tick(1);
        hu = '0;
        hd = '0;
        cr = '0;
    endtask

    task automatic probe_now(input string name, input logic [1:0] f, input logic [1:0] d, input logic o,
                             input logic [3:0] u, input logic [3:0] n, input logic [3:0] c);
        expect_ev(name, -1, f, d, o, u, n, c);
        probe = 1'b1;
        #1;
        probe = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected events never seen, want 0", name, q.size());
            q.delete();
        end
        tick(3);
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, want finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int c;
        for (int i = 0; i < 4; i++) begin
            hu   = 4'($urandom);
            hd   = 4'($urandom);
            cr   = 4'($urandom);
            hold = 1'($urandom);
            tick(1);
        end
        probe_now("in_reset", 2'd0, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);
        hu    = '0;
        hd    = '0;
        cr    = '0;
        hold  = 1'b0;
        rst_n = 1'b1;
        tick(3);
        probe_now("post_reset", 2'd0, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);

        c = cyc;
        expect_ev("b_latch",  c + 1,  2'd0, 2'b01, 1'b0, 4'b0, 4'b1000, 4'b0);
        expect_ev("b_fl1",    c + 5,  2'd1, 2'b01, 1'b0, 4'b0, 4'b1000, 4'b0);
        expect_ev("b_fl2",    c + 9,  2'd2, 2'b01, 1'b0, 4'b0, 4'b1000, 4'b0);
        expect_ev("b_door3",  c + 13, 2'd3, 2'b01, 1'b1, 4'b0, 4'b0,    4'b0);
        expect_ev("b_idle",   c + 19, 2'd3, 2'b00, 1'b0, 4'b0, 4'b0,    4'b0);
        press(4'b0, 4'b1000, 4'b0);
        drain("b_drain");

        c = cyc;
        expect_ev("c_door3",  c + 1,  2'd3, 2'b01, 1'b1, 4'b0, 4'b0, 4'b0);
        expect_ev("c_car1",   c + 3,  2'd3, 2'b01, 1'b1, 4'b0, 4'b0, 4'b0010);
        expect_ev("c_depart", c + 7,  2'd3, 2'b10, 1'b0, 4'b0, 4'b0, 4'b0010);
        expect_ev("c_fl2",    c + 11, 2'd2, 2'b10, 1'b0, 4'b0, 4'b0, 4'b0010);
        expect_ev("c_door1",  c + 15, 2'd1, 2'b10, 1'b1, 4'b0, 4'b0, 4'b0);
        expect_ev("c_idle",   c + 21, 2'd1, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);
        press(4'b0, 4'b0, 4'b1000);
        tick(1);
        press(4'b0, 4'b0, 4'b0010);
        drain("c_drain");

        c = cyc;
        expect_ev("g_dn",     c + 1,  2'd1, 2'b10, 1'b0, 4'b0, 4'b0, 4'b0001);
        expect_ev("g_door0",  c + 5,  2'd0, 2'b10, 1'b1, 4'b0, 4'b0, 4'b0);
        expect_ev("g_idle",   c + 11, 2'd0, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);
        press(4'b0, 4'b0, 4'b0001);
        drain("g_drain");

        c = cyc;
        expect_ev("d_up",     c + 1,  2'd0, 2'b01, 1'b0, 4'b0,    4'b0,    4'b1000);
        expect_ev("d_fl1",    c + 5,  2'd1, 2'b01, 1'b0, 4'b0,    4'b0,    4'b1000);
        press(4'b0, 4'b0, 4'b1000);
        tick(5);
        expect_ev("d_hall",   c + 7,  2'd1, 2'b01, 1'b0, 4'b0100, 4'b0010, 4'b1000);
        expect_ev("d_door2",  c + 9,  2'd2, 2'b01, 1'b1, 4'b0,    4'b0010, 4'b1000);
        expect_ev("d_dep2",   c + 15, 2'd2, 2'b01, 1'b0, 4'b0,    4'b0010, 4'b1000);
        expect_ev("d_door3",  c + 19, 2'd3, 2'b01, 1'b1, 4'b0,    4'b0010, 4'b0);
        expect_ev("d_rev",    c + 25, 2'd3, 2'b10, 1'b0, 4'b0,    4'b0010, 4'b0);
        expect_ev("d_fl2",    c + 29, 2'd2, 2'b10, 1'b0, 4'b0,    4'b0010, 4'b0);
        expect_ev("d_door1",  c + 33, 2'd1, 2'b10, 1'b1, 4'b0,    4'b0,    4'b0);
        expect_ev("d_idle",   c + 39, 2'd1, 2'b00, 1'b0, 4'b0,    4'b0,    4'b0);
        press(4'b0100, 4'b0010, 4'b0);
        drain("d_drain");

        press(4'b1000, 4'b0001, 4'b0);
        tick(2);
        probe_now("ignored_bits", 2'd1, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);

        c = cyc;
        expect_ev("e_door",   c + 1,  2'd1, 2'b01, 1'b1, 4'b0, 4'b0, 4'b0);
        expect_ev("e_close",  c + 17, 2'd1, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);
        press(4'b0, 4'b0, 4'b0010);
        hold = 1'b1;
        tick(2);
        press(4'b1010, 4'b0001, 4'b0);
        tick(7);
        hold = 1'b0;
        drain("e_drain");

        c = cyc;
        expect_ev("f_up",     c + 1,  2'd1, 2'b01, 1'b0, 4'b0, 4'b0, 4'b1000);
        expect_ev("f_fl2",    c + 5,  2'd2, 2'b01, 1'b0, 4'b0, 4'b0, 4'b1000);
        press(4'b0, 4'b0, 4'b1000);
        tick(5);
        rst_n = 1'b0;
        #1;
        probe_now("f_async_rst", 2'd0, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        probe_now("f_no_motion", 2'd0, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0);
        drain("f_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
